lms_controller: RTL and testbench

LMS_CONTROLLER -- requirements
Module: lms_controller

---
 rtl/lms_controller.sv | 147 ++++++++++++++
 tb/tb_lms_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lms_controller.sv
// LMS adaptive-filter sequencer: walks the datapath through reset, read,
// filter, error, weight-update and write-back steps for N_SAMPLES samples.
// Ports: clock, reset (async, active-high), start, abort, done_* step flags,
// step enables (*_active), busy, run_done, error, sample_count, err_state.
module lms_controller #(
  parameter int N_SAMPLES = 50,
  parameter int TIMEOUT   = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        done_read_Dn,
  input  logic        done_read_Xn,
  input  logic        done_yn,
  input  logic        done_en,
  input  logic        done_wn1,
  input  logic        done_write_wn,
  output logic        sys_reset_active,
  output logic        memory_Dn_active,
  output logic        memory_Xn_active,
  output logic        y_active,
  output logic        e_active,
  output logic        w_active,
  output logic        memory_bobot_active,
  output logic        busy,
  output logic        run_done,
  output logic        error,
  output logic [15:0] sample_count,
  output logic [3:0]  err_state
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    SYS_RST = 4'd1,
    RD_DN   = 4'd2,
    RD_XN   = 4'd3,
    CALC_Y  = 4'd4,
    CALC_E  = 4'd5,
    CALC_W  = 4'd6,
    WR_W    = 4'd7,
    NEXT    = 4'd8,
    DONE    = 4'd9,
    ERROR   = 4'd10
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] N_CNT    = 16'(N_SAMPLES);

  state_t      state;
  state_t      nxt;
  logic [15:0] wait_cnt;
  logic [15:0] cnt_inc;
  logic        is_step;
  logic        step_done;
  logic        tmo;

  // Saturating increment: the counter never wraps back to zero.
  assign cnt_inc = (sample_count == 16'hFFFF) ? sample_count
                                             : sample_count + 16'd1;

  always_comb begin
    is_step   = 1'b1;
    step_done = 1'b0;
    case (state)
      RD_DN:   step_done = done_read_Dn;
      RD_XN:   step_done = done_read_Xn;
      CALC_Y:  step_done = done_yn;
      CALC_E:  step_done = done_en;
      CALC_W:  step_done = done_wn1;
      WR_W:    step_done = done_write_wn;
      default: is_step   = 1'b0;
    endcase
  end

  // A done flag in the final allowed cycle beats the timeout.
  assign tmo = is_step && !step_done && (wait_cnt == TMO_LAST);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = SYS_RST;
      SYS_RST: nxt = RD_DN;
      RD_DN:   if (step_done) nxt = RD_XN;
      RD_XN:   if (step_done) nxt = CALC_Y;
      CALC_Y:  if (step_done) nxt = CALC_E;
      CALC_E:  if (step_done) nxt = CALC_W;
      CALC_W:  if (step_done) nxt = WR_W;
      WR_W:    if (step_done) nxt = NEXT;
      NEXT:    nxt = (cnt_inc == N_CNT) ? DONE : RD_DN;
      DONE:    nxt = IDLE;
      ERROR:   nxt = ERROR;
      default: nxt = IDLE;
    endcase
    if (tmo)   nxt = ERROR;
    if (abort) nxt = IDLE;
  end

  // Outputs are decoded from the next state so they are registered
  // yet line up with the state they belong to.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      wait_cnt            <= '0;
      sys_reset_active    <= 1'b0;
      memory_Dn_active    <= 1'b0;
      memory_Xn_active    <= 1'b0;
      y_active            <= 1'b0;
      e_active            <= 1'b0;
      w_active            <= 1'b0;
      memory_bobot_active <= 1'b0;
      busy                <= 1'b0;
      run_done            <= 1'b0;
      error               <= 1'b0;
      sample_count        <= '0;
      err_state           <= '0;
    end else begin
      state <= nxt;
      if (nxt != state)
        wait_cnt <= '0;
      else if (is_step && !step_done)
        wait_cnt <= wait_cnt + 16'd1;

      sys_reset_active    <= (nxt == SYS_RST);
      memory_Dn_active    <= (nxt == RD_DN);
      memory_Xn_active    <= (nxt == RD_XN);
      y_active            <= (nxt == CALC_Y);
      e_active            <= (nxt == CALC_E);
      w_active            <= (nxt == CALC_W);
      memory_bobot_active <= (nxt == WR_W);
      busy     <= !(nxt inside {IDLE, DONE, ERROR});
      run_done <= (nxt == DONE);
      error    <= (nxt == ERROR);

      if (state == IDLE && nxt == SYS_RST)
        sample_count <= '0;
      else if (state == NEXT && !abort)
        sample_count <= cnt_inc;

      if (abort)
        err_state <= '0;
      else if (tmo)
        err_state <= state;
    end
  end

endmodule

// File: tb/tb_lms_controller.sv
// Testbench for lms_controller: a cycle-by-cycle expected trace is built
// from per-step delays, then replayed against the DUT and compared.
module tb_lms_controller;

  localparam int NS = 2;
  localparam int TO = 4;

  typedef struct {
    logic [6:0]  en;
    logic        busy;
    logic        rd;
    logic        er;
    logic [15:0] cnt;
    logic [3:0]  es;
    logic [5:0]  dn;
    logic        ab;
    logic        st;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start, abort;
  logic        done_read_Dn, done_read_Xn, done_yn;
  logic        done_en, done_wn1, done_write_wn;
  logic        sys_reset_active, memory_Dn_active, memory_Xn_active;
  logic        y_active, e_active, w_active, memory_bobot_active;
  logic        busy, run_done, error;
  logic [15:0] sample_count;
  logic [3:0]  err_state;

  ent_t        q[$];
  ent_t        zero_e;
  logic [15:0] cnt_m;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          to;

  lms_controller #(.N_SAMPLES(NS), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .done_read_Dn(done_read_Dn), .done_read_Xn(done_read_Xn),
    .done_yn(done_yn), .done_en(done_en), .done_wn1(done_wn1),
    .done_write_wn(done_write_wn),
    .sys_reset_active(sys_reset_active),
    .memory_Dn_active(memory_Dn_active),
    .memory_Xn_active(memory_Xn_active),
    .y_active(y_active), .e_active(e_active), .w_active(w_active),
    .memory_bobot_active(memory_bobot_active),
    .busy(busy), .run_done(run_done), .error(error),
    .sample_count(sample_count), .err_state(err_state)
  );

  always #5 clock = ~clock;

  function automatic logic [5:0] rnd6();
    return 6'($urandom);
  endfunction

  task automatic push(input logic [6:0] en, input logic b, input logic rd,
                      input logic er, input logic [15:0] c,
                      input logic [3:0] es, input logic [5:0] dn,
                      input logic ab, input logic st);
    ent_t e;
    e.en = en; e.busy = b; e.rd = rd; e.er = er; e.cnt = c;
    e.es = es; e.dn = dn; e.ab = ab; e.st = st;
    q.push_back(e);
  endtask

  // Idle cycles; optionally pulse start on the last one.
  task automatic add_idle(input int n, input bit st_last);
    for (int i = 0; i < n; i++)
      push(7'd0, 0, 0, 0, cnt_m, 4'd0, rnd6(), 0, st_last && (i == n - 1));
  endtask

  task automatic add_sysrst();
    cnt_m = 16'd0;
    push(7'd1, 1, 0, 0, cnt_m, 4'd0, rnd6(), 0, 1'($urandom));
  endtask

  // Step s (1..6) answers d cycles after its enable rises; d >= TO
  // never answers. cut >= 0 truncates the step at that cycle.
  task automatic add_step(input int s, input int d, input int cut,
                          input bit cut_abort, output bit tmo);
    int len;
    logic [5:0] own, dn;
    len = (d >= TO) ? TO : d + 1;
    own = 6'(1 << (s - 1));
    tmo = (d >= TO) && (cut < 0);
    for (int j = 0; j < len; j++) begin
      if (cut >= 0 && j > cut) break;
      dn = rnd6() & ~own;
      if (j == d) dn = dn | own;
      push(7'(1 << s), 1, 0, 0, cnt_m, 4'd0, dn,
           cut_abort && (j == cut), 1'($urandom));
    end
  endtask

  task automatic add_next();
    push(7'd0, 1, 0, 0, cnt_m, 4'd0, rnd6(), 0, 1'($urandom));
    cnt_m = cnt_m + 16'd1;
  endtask

  task automatic add_done();
    push(7'd0, 0, 1, 0, cnt_m, 4'd0, rnd6(), 0, 1'($urandom));
  endtask

  // Error for n cycles (start pulses ignored), abort on the last one.
  task automatic add_error(input logic [3:0] code, input int n);
    for (int i = 0; i < n; i++)
      push(7'd0, 0, 0, 1, cnt_m, code, rnd6(), i == n - 1, 1'($urandom));
  endtask

  function automatic int rand_d();
    return ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, TO - 1));
  endfunction

  task automatic add_run(input int dmode, input bit rnd_abort);
    bit stop, t;
    int d, len;
    add_idle($urandom_range(1, 3), 1);
    add_sysrst();
    stop = 0;
    for (int k = 0; k < NS && !stop; k++) begin
      for (int s = 1; s <= 6 && !stop; s++) begin
        d = (dmode >= 0) ? dmode : rand_d();
        if (rnd_abort && $urandom_range(0, 19) == 0) begin
          len = (d >= TO) ? TO : d + 1;
          add_step(s, d, $urandom_range(0, len - 1), 1, t);
          stop = 1;
        end else begin
          add_step(s, d, -1, 0, t);
          if (t) begin
            add_error(4'(s + 1), $urandom_range(1, 3));
            stop = 1;
          end
        end
      end
      if (!stop) begin
        add_next();
        if (k == NS - 1) add_done();
      end
    end
    add_idle(2, 0);
  endtask

  task automatic check(input ent_t e, input string tag);
    logic [29:0] o, x;
    o = {memory_bobot_active, w_active, e_active, y_active,
         memory_Xn_active, memory_Dn_active, sys_reset_active,
         busy, run_done, error, sample_count, err_state};
    x = {e.en, e.busy, e.rd, e.er, e.cnt, e.es};
    tests++;
    assert (o === x) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, o, x);
    end
  endtask

  task automatic play();
    ent_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clock);
      check(e, $sformatf("cyc%0d", cyc));
      cyc++;
      {done_write_wn, done_wn1, done_en, done_yn,
       done_read_Xn, done_read_Dn} = e.dn;
      abort = e.ab;
      start = e.st;
    end
  endtask

  task automatic clear_inputs();
    start = 0; abort = 0;
    {done_write_wn, done_wn1, done_en, done_yn,
     done_read_Xn, done_read_Dn} = 6'd0;
  endtask

  initial begin
    zero_e = '{default: '0};
    reset = 1;
    clear_inputs();
    cnt_m = 16'd0;

    #1 check(zero_e, "reset_noclk");
    @(negedge clock);
    check(zero_e, "reset_state");
    reset = 0;

    // Two samples, every done one cycle after its enable rises.
    add_idle(2, 1);
    add_sysrst();
    for (int k = 0; k < NS; k++) begin
      for (int s = 1; s <= 6; s++) add_step(s, 1, -1, 0, to);
      add_next();
    end
    add_done();
    add_idle(3, 0);
    play();

    // Withheld done_yn: timeout in CALC_Y, then abort clears it.
    add_idle(1, 1);
    add_sysrst();
    add_step(1, 0, -1, 0, to);
    add_step(2, 0, -1, 0, to);
    add_step(3, TO + 2, -1, 0, to);
    add_error(4'd4, 3);
    add_idle(2, 0);
    play();

    // done_read_Xn lands in the last allowed cycle: no error.
    add_idle(1, 1);
    add_sysrst();
    add_step(1, 0, -1, 0, to);
    add_step(2, TO - 1, -1, 0, to);
    for (int s = 3; s <= 6; s++) add_step(s, rand_d() % TO, -1, 0, to);
    add_next();
    for (int s = 1; s <= 6; s++) add_step(s, TO - 1, -1, 0, to);
    add_next();
    add_done();
    add_idle(1, 0);
    play();

    // Abort in CALC_W of the second sample, then a fresh start.
    add_idle(1, 1);
    add_sysrst();
    for (int s = 1; s <= 6; s++) add_step(s, 0, -1, 0, to);
    add_next();
    for (int s = 1; s <= 4; s++) add_step(s, 2, -1, 0, to);
    add_step(5, 2, 1, 1, to);
    add_idle(2, 1);
    add_sysrst();
    add_step(1, 0, 0, 1, to);
    add_idle(1, 0);
    play();

    // Asynchronous reset in the middle of CALC_E.
    add_idle(1, 1);
    add_sysrst();
    for (int s = 1; s <= 3; s++) add_step(s, 1, -1, 0, to);
    add_step(4, 3, 1, 0, to);
    play();
    #2 reset = 1;
    #1 check(zero_e, "async_reset");
    clear_inputs();
    @(negedge clock);
    check(zero_e, "reset_hold");
    reset = 0;
    cnt_m = 16'd0;
    add_run(1, 0);
    play();

    // Randomized runs with occasional aborts and timeouts.
    repeat (30) begin
      add_run(-1, 1);
      play();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
